// File: rtl/wb_arbiter.sv
// Write-back arbiter merging ALU and multiplier results into one register-file port.
// Losers of a same-cycle contest wait in a 2-entry FIFO that is drained oldest first.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [RD_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mul_valid,
    input  logic [RD_W-1:0]   mul_rd,
    input  logic [DATA_W-1:0] mul_data,
    input  logic              kill,
    output logic              stall_out,
    output logic              wb_en,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       conflict_cnt
);

    logic [RD_W-1:0]   f_rd   [2];
    logic [DATA_W-1:0] f_data [2];
    logic [1:0]        count;

    logic [RD_W-1:0]   n_rd   [2];
    logic [DATA_W-1:0] n_data [2];
    logic [1:0]        n_count;
    logic              sel_v;
    logic [RD_W-1:0]   sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              acc_m;
    logic              acc_a;

    assign stall_out = (count == 2'd2);

    // rd == 0 results are accepted but vanish here
    assign acc_m = mul_valid && !stall_out && !kill && (mul_rd != '0);
    assign acc_a = alu_valid && !stall_out && !kill && (alu_rd != '0);

    always_comb begin
        n_rd     = f_rd;
        n_data   = f_data;
        n_count  = count;
        sel_v    = 1'b0;
        sel_rd   = wb_rd;
        sel_data = wb_data;
        unique case (count)
            2'd0: begin
                if (acc_m) begin
                    sel_v    = 1'b1;
                    sel_rd   = mul_rd;
                    sel_data = mul_data;
                    if (acc_a) begin
                        n_rd[0]   = alu_rd;
                        n_data[0] = alu_data;
                        n_count   = 2'd1;
                    end
                end else if (acc_a) begin
                    sel_v    = 1'b1;
                    sel_rd   = alu_rd;
                    sel_data = alu_data;
                end
            end
            2'd1: begin
                sel_v    = 1'b1;
                sel_rd   = f_rd[0];
                sel_data = f_data[0];
                if (acc_m) begin
                    n_rd[0]   = mul_rd;
                    n_data[0] = mul_data;
                    if (acc_a) begin
                        n_rd[1]   = alu_rd;
                        n_data[1] = alu_data;
                        n_count   = 2'd2;
                    end
                end else if (acc_a) begin
                    n_rd[0]   = alu_rd;
                    n_data[0] = alu_data;
                end else begin
                    n_count = 2'd0;
                end
            end
            default: begin
                sel_v     = 1'b1;
                sel_rd    = f_rd[0];
                sel_data  = f_data[0];
                n_rd[0]   = f_rd[1];
                n_data[0] = f_data[1];
                n_count   = 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= 2'd0;
            f_rd[0]      <= '0;
            f_rd[1]      <= '0;
            f_data[0]    <= '0;
            f_data[1]    <= '0;
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            conflict_cnt <= 16'd0;
        end else if (kill) begin
            count <= 2'd0;
            wb_en <= 1'b0;
        end else begin
            count  <= n_count;
            f_rd   <= n_rd;
            f_data <= n_data;
            wb_en  <= sel_v;
            if (sel_v) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
            if (acc_m && acc_a && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed and random traffic against a queue-based model.
// The model keeps pending results in arrival order and writes the oldest one each cycle.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mul_valid, kill;
    logic [RW-1:0] alu_rd, mul_rd;
    logic [DW-1:0] alu_data, mul_data;
    logic          stall_out, wb_en;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [15:0]   conflict_cnt;

    int compared   = 0;
    int mismatched = 0;

    ent_t          q[$];
    logic          m_en;
    logic [RW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic [15:0]   m_cnt;

    wb_arbiter #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data),
        .kill(kill), .stall_out(stall_out),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_cnt  = 16'd0;
    endtask

    task automatic check_all();
        chk("stall_out", 64'(stall_out), 64'(q.size() == 2));
        chk("wb_en", 64'(wb_en), 64'(m_en));
        chk("wb_rd", 64'(wb_rd), 64'(m_rd));
        chk("wb_data", 64'(wb_data), 64'(m_data));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    // Called at a negedge: drive one cycle, advance the model, check after the edge
    task automatic step(input logic mv, input logic [RW-1:0] mr,
                        input logic [DW-1:0] md, input logic av,
                        input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                        input logic k);
        logic am, aa;
        ent_t cand[$];
        ent_t e;
        mul_valid = mv; mul_rd = mr; mul_data = md;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        kill = k;
        am = mv && (q.size() < 2) && !k && (mr != 0);
        aa = av && (q.size() < 2) && !k && (ar != 0);
        if (k) begin
            q.delete();
            m_en = 1'b0;
        end else begin
            cand = q;
            if (am) begin e.rd = mr; e.data = md; cand.push_back(e); end
            if (aa) begin e.rd = ar; e.data = ad; cand.push_back(e); end
            if (am && aa && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (cand.size() > 0) begin
                e = cand.pop_front();
                m_en = 1'b1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_en = 1'b0;
            end
            q = cand;
        end
        chk("q_depth", 64'(q.size() <= 2), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        mul_valid = 0; alu_valid = 0; kill = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        chk("rst_stall", 64'(stall_out), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mul_valid = 0; mul_rd = 0; mul_data = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        kill = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        step(1, 3, 32'h10, 0, 0, 0, 0);
        chk("single_en", 64'(wb_en), 64'd1);
        chk("single_rd", 64'(wb_rd), 64'd3);
        idle(1);

        step(1, 1, 32'hA, 1, 2, 32'hB, 0);
        chk("dual_first", 64'(wb_rd), 64'd1);
        idle(1);
        chk("dual_second", 64'(wb_data), 64'hB);
        chk("dual_conflict", 64'(conflict_cnt), 64'd1);
        idle(1);

        step(1, 1, 32'h101, 1, 2, 32'h102, 0);
        step(1, 3, 32'h103, 1, 4, 32'h104, 0);
        chk("full_stall", 64'(stall_out), 64'd1);
        step(1, 5, 32'h105, 1, 6, 32'h106, 0);
        idle(4);

        step(0, 0, 0, 1, 0, 32'hFF, 0);
        chk("rd0_en", 64'(wb_en), 64'd0);
        idle(1);

        step(1, 7, 32'h7, 1, 8, 32'h8, 0);
        step(1, 9, 32'h9, 1, 10, 32'hA, 0);
        step(1, 11, 32'hB, 1, 12, 32'hC, 1);
        chk("kill_stall", 64'(stall_out), 64'd0);
        idle(3);

        step(1, 13, 32'hD, 1, 14, 32'hE, 0);
        async_reset();
        idle(3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 2) != 0, RW'($urandom_range(0, 7)),
                     $urandom, $urandom_range(0, 2) != 0,
                     RW'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 15) == 0);
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
